// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: icode constants, instruction-length lookup and
// instruction-memory size, reused by the loader and the fetch stage.
package y86_pkg;

  localparam int IMEM_BYTES = 1024;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } load_state_e;

  // Unrecognised icodes load as a single byte so fetch can flag them itself.
  function automatic logic [3:0] icode_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                    len = 4'd1;
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:    len = 4'd2;
      ICODE_JXX, ICODE_CALL:                               len = 4'd9;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:            len = 4'd10;
      default:                                             len = 4'd1;
    endcase
    return len;
  endfunction

  function automatic logic icode_known(input logic [3:0] icode);
    return icode <= ICODE_POPQ;
  endfunction

endpackage

// File: rtl/instr_window_loader_if.sv
// Request, instruction-memory and fetch-side signals of the instruction loader.
// slave is the loader; master is the surrounding fetch/memory environment.
interface instr_window_loader_if #(
  parameter int MEM_ADDR_W = 10
);

  logic [63:0]           pc_in;
  logic                  pc_valid;
  logic                  req_ready;
  logic                  flush;

  logic                  mem_rd_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [7:0]            mem_rd_data;

  logic [0:79]           current_instruction;
  logic [63:0]           instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  imem_error;

  modport slave (
    input  pc_in, pc_valid, flush, mem_rd_data, instr_ready,
    output req_ready, mem_rd_en, mem_addr,
           current_instruction, instr_pc, instr_valid, imem_error
  );

  modport master (
    output pc_in, pc_valid, flush, mem_rd_data, instr_ready,
    input  req_ready, mem_rd_en, mem_addr,
           current_instruction, instr_pc, instr_valid, imem_error
  );

endinterface

// File: rtl/instr_len_decode.sv
// Combinational icode -> instruction length decode for the first fetched byte.
module instr_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid
);

  assign len   = icode_len(icode);
  assign valid = icode_known(icode);

endmodule

// File: rtl/instr_window_loader.sv
// Byte-serial instruction loader: reads one instruction from byte-wide
// synchronous memory and presents an 80-bit big-endian window to fetch.
//
// state   | meaning
// IDLE    | waiting for a PC request, req_ready high
// LOAD    | issuing byte k, capturing byte k-1 from memory
// HOLD    | window complete, instr_valid high until instr_ready
module instr_window_loader
  import y86_pkg::*;
#(
  parameter int MEM_ADDR_W = $clog2(IMEM_BYTES)
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_window_loader_if.slave bus
);

  load_state_e state;
  logic [3:0]  k_q;
  logic [3:0]  len_q;
  logic [63:0] pc_q;
  logic [0:79] window_q;
  logic        err_q;
  logic        valid_q;

  logic [3:0]  dec_len;
  logic        dec_valid;
  logic [3:0]  need_len;
  logic        need_more;
  logic [64:0] addr_sum;
  logic        in_range;
  logic        issue;
  logic [6:0]  slot_base;

  instr_len_decode u_len_decode (
    .icode (bus.mem_rd_data[7:4]),
    .len   (dec_len),
    .valid (dec_valid)
  );

  // Byte 0 is on mem_rd_data while k==1, so its length gates byte 1 directly.
  always_comb begin
    need_len = len_q;
    if (k_q == 4'd1) begin
      need_len = dec_valid ? dec_len : 4'd1;
    end
    need_more = (k_q == 4'd0) || (k_q < need_len);
    addr_sum  = {1'b0, pc_q} + 65'(k_q);
    in_range  = (addr_sum >> MEM_ADDR_W) == 65'd0;
    issue     = (state == ST_LOAD) && need_more && in_range;
  end

  assign slot_base = {k_q - 4'd1, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      k_q      <= 4'd0;
      len_q    <= 4'd1;
      pc_q     <= 64'd0;
      window_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (bus.flush) begin
      state    <= ST_IDLE;
      k_q      <= 4'd0;
      window_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.pc_valid) begin
            pc_q     <= bus.pc_in;
            window_q <= '0;
            err_q    <= 1'b0;
            k_q      <= 4'd0;
            len_q    <= 4'd1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Any k>=1 implies byte k-1 was issued last cycle.
          if (k_q != 4'd0) begin
            window_q[slot_base +: 8] <= bus.mem_rd_data;
          end
          if (k_q == 4'd1) begin
            len_q <= need_len;
          end
          if (!need_more) begin
            state   <= ST_HOLD;
            valid_q <= 1'b1;
          end else if (!in_range) begin
            err_q   <= 1'b1;
            state   <= ST_HOLD;
            valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready           = (state == ST_IDLE);
  assign bus.mem_rd_en           = issue;
  assign bus.mem_addr            = issue ? addr_sum[MEM_ADDR_W-1:0] : '0;
  assign bus.current_instruction = window_q;
  assign bus.instr_pc            = pc_q;
  assign bus.instr_valid         = valid_q;
  assign bus.imem_error          = err_q;

endmodule

// File: tb/tb_instr_window_loader.sv
// Directed bench for instr_window_loader with a byte-wide synchronous memory
// model and a queue of expected windows popped when instr_valid rises.
module tb_instr_window_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_window_loader_if #(.MEM_ADDR_W(10)) bus ();

  instr_window_loader #(.MEM_ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [0:79] win;
    logic [63:0] pc;
    logic        err;
    int          lat;
    int          nreads;
  } exp_t;

  logic [7:0] mem [0:1023];
  logic [9:0] rd_log[$];
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= mem[bus.mem_addr];
      rd_log.push_back(bus.mem_addr);
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    int len;
    logic [7:0] b0;
    logic [63:0] a;
    e.win = '0; e.pc = pc; e.err = 1'b0; e.nreads = 0; e.lat = 1;
    if (pc > 64'd1023) begin
      e.err = 1'b1;
      return e;
    end
    b0 = mem[pc[9:0]];
    case (b0[7:4])
      4'h0, 4'h1, 4'h9:         len = 1;
      4'h2, 4'h6, 4'hA, 4'hB:   len = 2;
      4'h7, 4'h8:               len = 9;
      4'h3, 4'h4, 4'h5:         len = 10;
      default:                  len = 1;
    endcase
    for (int i = 0; i < len; i++) begin
      a = pc + 64'(i);
      if (a > 64'd1023) begin
        e.err = 1'b1;
        break;
      end
      e.win[8*i +: 8] = mem[a[9:0]];
      e.nreads++;
    end
    e.lat = e.nreads + 1;
    return e;
  endfunction

  task automatic run_req(input logic [63:0] pc, input int hold);
    exp_t e;
    int n;
    exp_q.push_back(model(pc));
    @(negedge clk);
    check("req_ready_before", 80'(bus.req_ready), 80'(1));
    bus.pc_in = pc;
    bus.pc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pc_valid = 1'b0;
    rd_log.delete();
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("valid_latency", 80'(n), 80'(e.lat));
    check("window", bus.current_instruction, e.win);
    check("instr_pc", 80'(bus.instr_pc), 80'(e.pc));
    check("imem_error", 80'(bus.imem_error), 80'(e.err));
    check("read_count", 80'(rd_log.size()), 80'(e.nreads));
    foreach (rd_log[i]) check("read_addr", 80'(rd_log[i]), 80'(pc + 64'(i)));
    for (int c = 0; c < hold; c++) begin
      bus.pc_valid = 1'b1;
      bus.pc_in = pc + 64'd100;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 80'(bus.instr_valid), 80'(1));
      check("hold_req_ready", 80'(bus.req_ready), 80'(0));
      check("hold_window", bus.current_instruction, e.win);
      check("hold_pc", 80'(bus.instr_pc), 80'(e.pc));
    end
    bus.pc_valid = 1'b0;
    check("hold_no_reads", 80'(rd_log.size()), 80'(e.nreads));
    bus.instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    check("release_valid", 80'(bus.instr_valid), 80'(0));
    check("release_req_ready", 80'(bus.req_ready), 80'(1));
  endtask

  task automatic start_only(input logic [63:0] pc);
    @(negedge clk);
    bus.pc_in = pc;
    bus.pc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pc_in = 64'd0;
    bus.pc_valid = 1'b0;
    bus.flush = 1'b0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h30;
    mem[1] = 8'hF3;
    for (int i = 2; i < 10; i++) mem[i] = 8'(i - 1);

    repeat (2) @(negedge clk);
    check("rst_req_ready", 80'(bus.req_ready), 80'(1));
    check("rst_instr_valid", 80'(bus.instr_valid), 80'(0));
    check("rst_imem_error", 80'(bus.imem_error), 80'(0));
    check("rst_window", bus.current_instruction, 80'd0);
    check("rst_instr_pc", 80'(bus.instr_pc), 80'(0));
    check("rst_mem_rd_en", 80'(bus.mem_rd_en), 80'(0));
    check("rst_mem_addr", 80'(bus.mem_addr), 80'(0));
    rst_n = 1'b1;

    // irmovq at 0, held for 5 cycles with pc_valid pulsing
    run_req(64'd0, 5);
    check("irmovq_literal", 80'(model(64'd0).win), 80'h30F3_0102_0304_0506_0708);

    mem[5] = 8'h60;
    mem[6] = 8'h23;
    mem[7] = 8'h99;
    run_req(64'd5, 0);

    mem[1020] = 8'h70;
    mem[1021] = 8'hAA;
    mem[1022] = 8'hBB;
    mem[1023] = 8'hCC;
    run_req(64'd1020, 0);
    run_req(64'd2000, 0);
    run_req(64'hFFFF_FFFF_FFFF_FFF8, 0);

    mem[1023] = 8'h60;
    run_req(64'd1023, 0);
    mem[1023] = 8'h10;
    run_req(64'd1023, 0);

    // flush mid-LOAD of a 10-byte instruction with pc_valid on the same edge
    start_only(64'd0);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_in = 64'd5;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.pc_valid = 1'b0;
    check("flush_req_ready", 80'(bus.req_ready), 80'(1));
    check("flush_valid", 80'(bus.instr_valid), 80'(0));
    check("flush_error", 80'(bus.imem_error), 80'(0));
    check("flush_rd_en", 80'(bus.mem_rd_en), 80'(0));

    // flush beats an accept while idle
    bus.flush = 1'b1;
    bus.pc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.pc_valid = 1'b0;
    check("flush_idle_no_accept", 80'(bus.req_ready), 80'(1));
    check("flush_idle_rd_en", 80'(bus.mem_rd_en), 80'(0));
    run_req(64'd0, 0);

    // reset for one cycle mid-LOAD, then a clean load
    start_only(64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 80'(bus.req_ready), 80'(1));
    check("midrst_valid", 80'(bus.instr_valid), 80'(0));
    check("midrst_rd_en", 80'(bus.mem_rd_en), 80'(0));
    check("midrst_window", bus.current_instruction, 80'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(64'd5, 0);

    for (int r = 0; r < 6; r++) begin
      int p;
      p = int'($urandom_range(0, 1023));
      mem[p] = {4'($urandom_range(0, 15)), 4'h5};
      run_req(64'(p), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
